// File: rtl/rd_port_arbiter_pkg.sv
// Shared definitions for the read-port arbiter.
//   BURST_W  : width of the addr_gen burst code (log2 of beat count)
//   MAX_NREQ : upper bound on requesters, sizes the round-robin helper
//   ms_state_e : master-stage states
//   rr_pick  : first set bit of pend at or after ptr, wrapping over n bits
package rd_port_arbiter_pkg;
    localparam int BURST_W  = 4;
    localparam int MAX_NREQ = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } ms_state_e;

    // Caller only uses the result when some pend bit is set.
    function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] pend,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned w;
        int unsigned idx;
        logic found;
        w     = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = (ptr + k) % n;
            if (k < n && !found && pend[idx[2:0]]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction
endpackage

// File: rtl/rd_port_arbiter_if.sv
// Handshake bundle between NREQ address generators, the arbiter and the
// AXI read port.
//   req_*  : per-requester request pulses, acks and routed R beats
//   m_*    : master AR channel and R beat qualifiers
// modport master : arbiter side; slave : generators + AXI port side.
interface rd_port_arbiter_if
    import rd_port_arbiter_pkg::*;
#(
    parameter int AW   = 32,
    parameter int NREQ = 2
);
    logic [NREQ*AW-1:0]      req_araddr;
    logic [NREQ*BURST_W-1:0] req_arburst;
    logic [NREQ-1:0]         req_arvalid;
    logic [NREQ-1:0]         req_arack;
    logic [NREQ-1:0]         req_rvalid;
    logic [NREQ-1:0]         req_rlast;
    logic [AW-1:0]           m_araddr;
    logic [BURST_W-1:0]      m_arburst;
    logic                    m_arvalid;
    logic                    m_arready;
    logic                    m_rvalid;
    logic                    m_rlast;

    modport master (
        input  req_araddr, req_arburst, req_arvalid, m_arready, m_rvalid, m_rlast,
        output req_arack, req_rvalid, req_rlast, m_araddr, m_arburst, m_arvalid
    );
    modport slave (
        output req_araddr, req_arburst, req_arvalid, m_arready, m_rvalid, m_rlast,
        input  req_arack, req_rvalid, req_rlast, m_araddr, m_arburst, m_arvalid
    );
endinterface

// File: rtl/rd_port_arbiter_sync_fifo.sv
// Small synchronous FIFO holding the requester index of each issued burst
// in issue order.
//   clk, rst_n : clock, async active-low reset
//   push/din   : write; allowed when full only together with pop
//   pop/dout   : read of head entry; dout valid while !empty
//   empty      : no entries
//   count      : occupancy 0..DEPTH
module sync_fifo
    import rd_port_arbiter_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
endmodule

// File: rtl/rd_port_arbiter.sv
// Shares one AXI read port among NREQ address generators. Generator pulses
// are latched (they have no ready), granted round-robin onto the master AR
// stage, and in-order R beats are steered back to the burst owner.
//   clk, rst_n : clock, async active-low reset
//   bus        : request / master AR / R routing bundle (master modport)
//   busy       : registered: pending request, AR valid or burst in flight
//   err        : sticky: request overwritten before grant, or orphan R beat
module rd_port_arbiter
    import rd_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int NREQ     = 2,
    parameter int MAX_OUTS = 4,
    localparam int IDW     = $clog2(NREQ),
    localparam int CW      = $clog2(MAX_OUTS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rd_port_arbiter_if.master     bus,
    output logic                  busy,
    output logic                  err
);
    typedef struct packed {
        logic [AW-1:0]      addr;
        logic [BURST_W-1:0] burst;
    } rd_req_t;

    logic [NREQ-1:0] pend_q, pend_d;
    rd_req_t         req_q [NREQ];
    rd_req_t         req_d [NREQ];
    logic [IDW-1:0]  rr_ptr_q, win, rr_nxt;
    ms_state_e       state_q;
    rd_req_t         m_req_q;
    logic            m_arvalid_q;
    logic [NREQ-1:0] arack_q;
    logic            busy_q, busy_d, err_q, err_d;

    logic            last_beat, pop, load, orphan, ovf, arvalid_nxt;
    logic [IDW-1:0]  head;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt, cnt_nxt;
    logic [NREQ-1:0] rvalid_o, rlast_o;

    always_comb begin
        last_beat = bus.m_rvalid & bus.m_rlast;
        pop       = last_beat & ~fifo_empty;
        orphan    = bus.m_rvalid & fifo_empty;
        win       = IDW'(rr_pick(MAX_NREQ'(pend_q), 32'(rr_ptr_q), NREQ));
        rr_nxt    = (int'(win) + 1 == NREQ) ? '0 : win + 1'b1;
        // A completing burst frees its slot in the same cycle, so a full
        // queue can still accept a new grant.
        load      = (state_q == ST_IDLE || bus.m_arready) && (|pend_q) &&
                    (fifo_cnt < CW'(MAX_OUTS) || pop);
    end

    // Request capture. A pulse on the edge that grants the same requester
    // simply re-arms it; otherwise a pulse onto a pending slot overwrites it.
    always_comb begin
        pend_d = pend_q;
        req_d  = req_q;
        ovf    = 1'b0;
        if (load) pend_d[win] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_arvalid[i]) begin
                if (pend_q[i] && !(load && win == IDW'(i))) ovf = 1'b1;
                pend_d[i]      = 1'b1;
                req_d[i].addr  = bus.req_araddr[i*AW +: AW];
                req_d[i].burst = bus.req_arburst[i*BURST_W +: BURST_W];
            end
        end
        err_d       = err_q | ovf | orphan;
        cnt_nxt     = fifo_cnt + CW'(load) - CW'(pop);
        arvalid_nxt = load | (m_arvalid_q & ~bus.m_arready);
        busy_d      = (|pend_d) | arvalid_nxt | (cnt_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            for (int i = 0; i < NREQ; i++) req_q[i] <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            req_q  <= req_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    // Master stage: outputs are held while ISSUE waits for m_arready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            m_req_q     <= '0;
            m_arvalid_q <= 1'b0;
            arack_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            arack_q <= '0;
            if (load) begin
                state_q      <= ST_ISSUE;
                m_req_q      <= req_q[win];
                m_arvalid_q  <= 1'b1;
                arack_q[win] <= 1'b1;
                rr_ptr_q     <= rr_nxt;
            end else if (state_q == ST_ISSUE && bus.m_arready) begin
                state_q     <= ST_IDLE;
                m_arvalid_q <= 1'b0;
            end
        end
    end

    sync_fifo #(.W(IDW), .DEPTH(MAX_OUTS)) u_order (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (load),
        .din   (win),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // R routing; beats with no owner are dropped.
    always_comb begin
        rvalid_o = '0;
        rlast_o  = '0;
        if (bus.m_rvalid && !fifo_empty) begin
            rvalid_o[head] = 1'b1;
            rlast_o[head]  = bus.m_rlast;
        end
    end

    assign bus.req_rvalid = rvalid_o;
    assign bus.req_rlast  = rlast_o;
    assign bus.req_arack  = arack_q;
    assign bus.m_araddr   = m_req_q.addr;
    assign bus.m_arburst  = m_req_q.burst;
    assign bus.m_arvalid  = m_arvalid_q;
    assign busy           = busy_q;
    assign err            = err_q;
endmodule
